// File: rtl/freq_meas_ctrl.sv
// Equal-precision gate sequencer: opens and closes the measurement window on
// synchronized clk_fx rising edges and reports reference and clk_fx counts.
module freq_meas_ctrl #(
    parameter logic [25:0] GATE_CYCLES    = 26'd50_000_000,
    parameter logic [26:0] TIMEOUT_CYCLES = 27'd100_000_000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             clk_fx,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cnt_ref,
    output logic [CNT_W-1:0] cnt_fx
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_OPEN,
        GATE,
        CLOSE,
        DONE,
        ABORT
    } state_t;

    localparam logic [26:0]      TIMEOUT_LAST = TIMEOUT_CYCLES - 27'd1;
    localparam logic [CNT_W-1:0] GATE_LEN     = CNT_W'(GATE_CYCLES);

    state_t           state, state_nxt;
    logic             fx_s1, fx_s2, fx_s3;
    logic             fx_rise;
    logic [CNT_W-1:0] ref_i, ref_i_nxt;
    logic [CNT_W-1:0] fx_i, fx_i_nxt;
    logic [CNT_W-1:0] ref_inc, fx_inc;
    logic [CNT_W-1:0] cnt_ref_nxt, cnt_fx_nxt;
    logic [26:0]      timer, timer_nxt;
    logic             gate_full;
    logic             timer_expired;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            fx_s1 <= 1'b0;
            fx_s2 <= 1'b0;
            fx_s3 <= 1'b0;
        end else begin
            fx_s1 <= clk_fx;
            fx_s2 <= fx_s1;
            fx_s3 <= fx_s2;
        end
    end

    assign fx_rise = fx_s2 & ~fx_s3;

    assign ref_inc       = (ref_i == {CNT_W{1'b1}}) ? ref_i : ref_i + 1'b1;
    assign fx_inc        = (fx_i == {CNT_W{1'b1}}) ? fx_i : fx_i + 1'b1;
    assign gate_full     = (ref_inc >= GATE_LEN);
    assign timer_expired = (timer == TIMEOUT_LAST);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= IDLE;
            ref_i   <= '0;
            fx_i    <= '0;
            timer   <= '0;
            cnt_ref <= '0;
            cnt_fx  <= '0;
        end else begin
            state   <= state_nxt;
            ref_i   <= ref_i_nxt;
            fx_i    <= fx_i_nxt;
            timer   <= timer_nxt;
            cnt_ref <= cnt_ref_nxt;
            cnt_fx  <= cnt_fx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ref_i_nxt   = ref_i;
        fx_i_nxt    = fx_i;
        timer_nxt   = timer;
        cnt_ref_nxt = cnt_ref;
        cnt_fx_nxt  = cnt_fx;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_OPEN;
                    timer_nxt = '0;
                end
            end
            WAIT_OPEN: begin
                if (fx_rise) begin
                    state_nxt = GATE;
                    ref_i_nxt = '0;
                    fx_i_nxt  = '0;
                    timer_nxt = '0;
                end else if (timer_expired) begin
                    state_nxt   = ABORT;
                    cnt_ref_nxt = '0;
                    cnt_fx_nxt  = '0;
                end else begin
                    timer_nxt = timer + 27'd1;
                end
            end
            GATE: begin
                ref_i_nxt = ref_inc;
                if (fx_rise) begin
                    fx_i_nxt = fx_inc;
                end
                // An edge landing exactly on gate expiry closes the window at once
                if (fx_rise && gate_full) begin
                    state_nxt   = DONE;
                    cnt_ref_nxt = ref_inc;
                    cnt_fx_nxt  = fx_inc;
                end else if (gate_full) begin
                    state_nxt = CLOSE;
                    timer_nxt = '0;
                end
            end
            CLOSE: begin
                ref_i_nxt = ref_inc;
                timer_nxt = timer + 27'd1;
                if (fx_rise) begin
                    state_nxt   = DONE;
                    cnt_ref_nxt = ref_inc;
                    cnt_fx_nxt  = fx_inc;
                end else if (timer_expired) begin
                    state_nxt   = ABORT;
                    cnt_ref_nxt = '0;
                    cnt_fx_nxt  = '0;
                end
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE) || (state == ABORT);
    assign timeout = (state == ABORT);

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Equal-precision gate sequencer for the cymometer.
- Opens and closes the measurement window on rising edges of the clock under test (clk_fx), e.g. the divided test clock.
- Counts reference cycles and clk_fx periods inside the window and presents both counts with a done pulse.
- Downstream logic computes f_fx = f_clk_in * cnt_fx / cnt_ref.

Parameters:
- GATE_CYCLES, 26'd50_000_000, minimum gate length in clk_in cycles (1 s at 50 MHz).
- TIMEOUT_CYCLES, 27'd100_000_000, clk_in cycles without a clk_fx rise before abort, in WAIT_OPEN or CLOSE.
- CNT_W, 32, width of the result counters.

Ports:
- clk_in, input, 1, system/reference clock.
- rst, input, 1, reset.
- start, input, 1, single-cycle measurement request; ignored while busy.
- clk_fx, input, 1, clock under test, asynchronous to clk_in, f_fx < f_clk_in/2.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when results are updated.
- timeout, output, 1, high with done when the measurement aborted.
- cnt_ref, output, CNT_W, clk_in cycles inside the gate.
- cnt_fx, output, CNT_W, whole clk_fx periods inside the gate.

Behaviour:
- Clocking/reset: single clock clk_in. Reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, timeout=0, cnt_ref=0, cnt_fx=0; sync flops and internal counters 0.
- Reset mid-operation: immediate return to IDLE, no done pulse.
- Edge detection: clk_fx passes through a 2-FF synchronizer plus a delay flop. fx_rise = s2 & ~s3, one cycle wide.
  - Latency from the clk_fx edge to fx_rise is 2-3 clk_in cycles. Latency is constant, so it cancels in the counts.
- IDLE: on start=1, go to WAIT_OPEN and clear timer.
- WAIT_OPEN: timer increments each cycle.
  - On fx_rise: go to GATE; ref_i=0, fx_i=0, timer=0.
  - On timer==TIMEOUT_CYCLES-1 without fx_rise: go to ABORT.
- GATE: each cycle ref_i+=1; on fx_rise, fx_i+=1.
  - If fx_rise and ref_i+1 >= GATE_CYCLES (simultaneous expiry and edge): latch cnt_ref=ref_i+1, cnt_fx=fx_i+1, go to DONE.
  - Else if ref_i+1 >= GATE_CYCLES: go to CLOSE, timer=0.
- CLOSE: each cycle ref_i+=1 and timer+=1.
  - On fx_rise: latch cnt_ref=ref_i+1, cnt_fx=fx_i+1, go to DONE.
  - On timer==TIMEOUT_CYCLES-1 without fx_rise: go to ABORT.
- DONE: done=1 for this cycle, timeout=0, then go to IDLE.
- ABORT: done=1, timeout=1, cnt_ref=0, cnt_fx=0 for one cycle, then go to IDLE.
- Output hold: cnt_ref and cnt_fx hold their values until the next DONE or ABORT. timeout returns to 0 after the pulse.
- Counter widths: ref_i and fx_i are CNT_W wide and saturate at all-ones (no wrap). Timer is 27 bits.
- start handling: start while busy (including the DONE/ABORT cycle) is dropped, not queued. start in IDLE is accepted the same cycle, so busy=1 on the next cycle.
- Result meaning: cnt_ref is the number of clk_in cycles strictly between the opening fx_rise and the closing fx_rise, inclusive of the closing cycle. It equals cnt_fx * T_fx / T_clk_in, exact to ±1 cycle of synchronizer jitter per edge.

Test Plan:
- GATE_CYCLES=20, TIMEOUT_CYCLES=100, clk_fx = clk_in/10 (toggle every 5 cycles); pulse start -> done after the second fx_rise past open; cnt_ref=20, cnt_fx=2, timeout=0, busy low the cycle after done.
- Same parameters, clk_fx period 7 clk_in cycles -> gate expires at 20, closes at next edge; cnt_ref=21, cnt_fx=3.
- clk_fx held 0, start -> exactly 100 cycles later done=1, timeout=1, cnt_ref=0, cnt_fx=0; next cycle busy=0.
- clk_fx period 10; start, then start again every cycle during the measurement -> exactly one done pulse, results 20/2, no second measurement until start after busy=0.
- rst=1 for one cycle in the middle of GATE -> next cycle busy=0, done=0, cnt_ref=0, cnt_fx=0. A new start then yields 20/2 normally.
- clk_fx stops (held 1) after the gate opens -> CLOSE times out after 100 cycles: done=1, timeout=1, counts 0.
